// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared widths and state encoding for the seven-segment display scheduler
package sevenseg_pkg;

    localparam int BIN_W  = 13;
    localparam int BCD_W  = 16;
    localparam int DIGITS = 4;
    localparam int IDX_W  = 3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARB     = 3'd1;
    localparam logic [2:0] ST_START   = 3'd2;
    localparam logic [2:0] ST_WAIT_DV = 3'd3;
    localparam logic [2:0] ST_SHOW    = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        ARB     = ST_ARB,
        START   = ST_START,
        WAIT_DV = ST_WAIT_DV,
        SHOW    = ST_SHOW
    } state_t;

endpackage

// File: rtl/rr_arbiter_pick.sv
// rtl/rr_arbiter_pick.sv - combinational round-robin pick starting after the last owner
module rr_arbiter_pick
    import sevenseg_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [7:0]       req_ext;
    logic [IDX_W-1:0] k;

    // Search ptr+1, ptr+2, ... wrapping, so the previous owner is considered last.
    always_comb begin
        req_ext = 8'(req);
        idx     = '0;
        any     = 1'b0;
        k       = '0;
        for (int i = 1; i <= N; i++) begin
            k = IDX_W'((int'(ptr) + i) % N);
            if (!any && req_ext[k]) begin
                any = 1'b1;
                idx = k;
            end
        end
    end

    assign grant = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/sevenseg_display_scheduler.sv
// rtl/sevenseg_display_scheduler.sv - time-shares the 4-digit display among requesters via a handshaked BCD converter
module sevenseg_display_scheduler
    import sevenseg_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int HOLD_CYCLES    = 25_000_000,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     i_CLK,
    input  logic                     i_RESET,
    input  logic [NUM_REQ-1:0]       i_Req,
    input  logic [BIN_W*NUM_REQ-1:0] i_Values,
    output logic [NUM_REQ-1:0]       o_Grant,
    output logic [2:0]               o_Source,
    output logic [BIN_W-1:0]         o_Bin,
    output logic                     o_Bin_Start,
    input  logic [BCD_W-1:0]         i_BCD,
    input  logic                     i_BCD_DV,
    output logic [BCD_W-1:0]         o_BCD4x4,
    output logic                     o_Valid,
    output logic                     o_Timeout
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [TMO_W-1:0]   tmo_cnt;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic [BIN_W-1:0]   vals [8];

    for (genvar g = 0; g < 8; g++) begin : g_vals
        if (g < NUM_REQ) begin : g_used
            assign vals[g] = i_Values[BIN_W*g +: BIN_W];
        end else begin : g_pad
            assign vals[g] = '0;
        end
    end

    rr_arbiter_pick #(
        .N(NUM_REQ)
    ) u_arb (
        .req  (i_Req),
        .ptr  (ptr),
        .grant(arb_grant),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state       <= IDLE;
            ptr         <= IDX_W'(NUM_REQ - 1);
            hold_cnt    <= '0;
            tmo_cnt     <= '0;
            o_Grant     <= '0;
            o_Source    <= '0;
            o_Bin       <= '0;
            o_Bin_Start <= 1'b0;
            o_BCD4x4    <= '0;
            o_Valid     <= 1'b0;
            o_Timeout   <= 1'b0;
        end else begin
            o_Bin_Start <= 1'b0;
            o_Timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|i_Req) state <= ARB;
                end
                ARB: begin
                    // Start pulse is registered here so it is high for exactly the START cycle.
                    if (arb_any) begin
                        o_Grant     <= arb_grant;
                        o_Source    <= arb_idx;
                        ptr         <= arb_idx;
                        o_Bin       <= vals[arb_idx];
                        o_Bin_Start <= 1'b1;
                        state       <= START;
                    end else begin
                        state <= IDLE;
                    end
                end
                START: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_DV;
                end
                WAIT_DV: begin
                    if (i_BCD_DV) begin
                        o_BCD4x4 <= i_BCD;
                        o_Valid  <= 1'b1;
                        hold_cnt <= '0;
                        state    <= SHOW;
                    end else if (tmo_cnt == TMO_LAST) begin
                        o_Timeout <= 1'b1;
                        o_Grant   <= '0;
                        state     <= ARB;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (hold_cnt == HOLD_LAST) begin
                        o_Grant <= '0;
                        state   <= ARB;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sevenseg_display_scheduler.sv
// tb/tb_sevenseg_display_scheduler.sv - directed self-checking bench for the display scheduler
module tb_sevenseg_display_scheduler;

    localparam int NUM_REQ        = 4;
    localparam int HOLD_CYCLES    = 8;
    localparam int TIMEOUT_CYCLES = 4;

    logic        i_CLK = 1'b0;
    logic        i_RESET = 1'b1;
    logic [3:0]  i_Req = 4'b0000;
    logic [12:0] tv [4];
    logic [51:0] i_Values;
    logic [3:0]  o_Grant;
    logic [2:0]  o_Source;
    logic [12:0] o_Bin;
    logic        o_Bin_Start;
    logic [15:0] i_BCD;
    logic        i_BCD_DV;
    logic [15:0] o_BCD4x4;
    logic        o_Valid;
    logic        o_Timeout;

    logic        conv_en = 1'b1;
    logic        model_dv = 1'b0;
    logic [15:0] model_bcd = 16'h0;
    int          conv_cnt = 0;
    logic        man_dv = 1'b0;
    logic [15:0] man_bcd = 16'h0;

    int checks = 0;
    int errors = 0;

    always #5 i_CLK = ~i_CLK;

    assign i_Values = {tv[3], tv[2], tv[1], tv[0]};
    assign i_BCD_DV = model_dv | man_dv;
    assign i_BCD    = man_dv ? man_bcd : model_bcd;

    sevenseg_display_scheduler #(
        .NUM_REQ       (NUM_REQ),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .i_CLK      (i_CLK),
        .i_RESET    (i_RESET),
        .i_Req      (i_Req),
        .i_Values   (i_Values),
        .o_Grant    (o_Grant),
        .o_Source   (o_Source),
        .o_Bin      (o_Bin),
        .o_Bin_Start(o_Bin_Start),
        .i_BCD      (i_BCD),
        .i_BCD_DV   (i_BCD_DV),
        .o_BCD4x4   (o_BCD4x4),
        .o_Valid    (o_Valid),
        .o_Timeout  (o_Timeout)
    );

    function automatic logic [15:0] to_bcd(input logic [12:0] v);
        int x;
        x = int'(v);
        return {4'(x / 1000 % 10), 4'(x / 100 % 10), 4'(x / 10 % 10), 4'(x % 10)};
    endfunction

    // Converter stand-in: DV three cycles after the start pulse, converting the value on o_Bin then.
    always @(negedge i_CLK) begin
        if (i_RESET || !conv_en) begin
            conv_cnt <= 0;
            model_dv <= 1'b0;
        end else if (o_Bin_Start) begin
            conv_cnt <= 2;
            model_dv <= 1'b0;
        end else if (conv_cnt == 1) begin
            conv_cnt  <= 0;
            model_dv  <= 1'b1;
            model_bcd <= to_bcd(o_Bin);
        end else begin
            if (conv_cnt > 0) conv_cnt <= conv_cnt - 1;
            model_dv <= 1'b0;
        end
    end

    task automatic tick();
        @(negedge i_CLK);
    endtask

    task automatic do_reset();
        i_RESET = 1'b1;
        i_Req   = 4'b0000;
        man_dv  = 1'b0;
        for (int k = 0; k < 4; k++) tv[k] = 13'd0;
        tick();
        tick();
        i_RESET = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (o_Bin_Start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_RESET = 1'b1;
        i_Req   = 4'b1111;
        tick();
        tick();
        checks++; if (o_Grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", o_Grant); end
        checks++; if (o_Source !== 3'd0) begin errors++; $display("FAIL reset_source: got %0d want 0", o_Source); end
        checks++; if (o_Bin !== 13'd0) begin errors++; $display("FAIL reset_bin: got %0d want 0", o_Bin); end
        checks++; if (o_Bin_Start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", o_Bin_Start); end
        checks++; if (o_BCD4x4 !== 16'h0000) begin errors++; $display("FAIL reset_bcd: got %h want 0000", o_BCD4x4); end
        checks++; if (o_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_Valid); end
        checks++; if (o_Timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", o_Timeout); end
        i_RESET = 1'b0;
        i_Req   = 4'b0000;
        tick();
        tick();
        tick();
        checks++; if (o_Bin_Start !== 1'b0 || o_Grant !== 4'b0000) begin errors++; $display("FAIL idle_no_req: start %b grant %b want 0 0000", o_Bin_Start, o_Grant); end
    endtask

    task automatic test_single();
        do_reset();
        tv[0] = 13'd1234;
        i_Req = 4'b0001;
        tick();
        checks++; if (o_Bin_Start !== 1'b0 || o_Grant !== 4'b0000) begin errors++; $display("FAIL single_arb: start %b grant %b want 0 0000", o_Bin_Start, o_Grant); end
        tick();
        checks++; if (o_Bin_Start !== 1'b1) begin errors++; $display("FAIL single_start_latency: got %b want 1", o_Bin_Start); end
        checks++; if (o_Grant !== 4'b0001 || o_Source !== 3'd0) begin errors++; $display("FAIL single_grant: grant %b src %0d want 0001 0", o_Grant, o_Source); end
        checks++; if (o_Bin !== 13'd1234) begin errors++; $display("FAIL single_bin: got %0d want 1234", o_Bin); end
        tick();
        checks++; if (o_Bin_Start !== 1'b0) begin errors++; $display("FAIL single_start_pulse: got %b want 0", o_Bin_Start); end
        tick();
        checks++; if (o_Valid !== 1'b0) begin errors++; $display("FAIL single_valid_early: got %b want 0", o_Valid); end
        tick();
        checks++; if (o_BCD4x4 !== 16'h1234 || o_Valid !== 1'b1) begin errors++; $display("FAIL single_result: bcd %h valid %b want 1234 1", o_BCD4x4, o_Valid); end
        for (int j = 0; j < 8; j++) begin
            checks++; if (o_Grant !== 4'b0001) begin errors++; $display("FAIL single_hold_%0d: grant %b want 0001", j, o_Grant); end
            tick();
        end
        checks++; if (o_Grant !== 4'b0000) begin errors++; $display("FAIL single_release: grant %b want 0000", o_Grant); end
        i_Req = 4'b0000;
    endtask

    task automatic test_round_robin();
        logic [2:0]  src_seen [5];
        logic [15:0] res_seen [4];
        logic [2:0]  exp_src  [5];
        logic [15:0] exp_res  [4];
        logic [15:0] last;
        int n_start, n_res, bad2, multi;
        exp_src = '{3'd0, 3'd1, 3'd3, 3'd0, 3'd1};
        exp_res = '{16'h0001, 16'h0002, 16'h0004, 16'h0001};
        n_start = 0; n_res = 0; bad2 = 0; multi = 0;
        last = 16'h0000;
        for (int k = 0; k < 5; k++) src_seen[k] = 3'd7;
        for (int k = 0; k < 4; k++) res_seen[k] = 16'hffff;
        do_reset();
        tv[0] = 13'd1; tv[1] = 13'd2; tv[2] = 13'd3; tv[3] = 13'd4;
        i_Req = 4'b1011;
        for (int c = 0; c < 120 && n_start < 5; c++) begin
            tick();
            if (o_Bin_Start === 1'b1) begin
                src_seen[n_start] = o_Source;
                n_start++;
            end
            if (o_BCD4x4 !== last && n_res < 4) begin
                res_seen[n_res] = o_BCD4x4;
                n_res++;
                last = o_BCD4x4;
            end
            if (o_Grant === 4'b0100) bad2++;
            if ($countones(o_Grant) > 1) multi++;
        end
        checks++; if (n_start != 5) begin errors++; $display("FAIL rr_start_count: got %0d want 5", n_start); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (src_seen[k] !== exp_src[k]) begin errors++; $display("FAIL rr_order_%0d: got %0d want %0d", k, src_seen[k], exp_src[k]); end
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (res_seen[k] !== exp_res[k]) begin errors++; $display("FAIL rr_result_%0d: got %h want %h", k, res_seen[k], exp_res[k]); end
        end
        checks++; if (bad2 != 0) begin errors++; $display("FAIL rr_src2_granted: got %0d cycles want 0", bad2); end
        checks++; if (multi != 0) begin errors++; $display("FAIL rr_multi_hot: got %0d cycles want 0", multi); end
        i_Req = 4'b0000;
    endtask

    task automatic test_refresh();
        bit ok;
        do_reset();
        tv[0] = 13'd17;
        i_Req = 4'b0001;
        wait_start(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL refresh_start1: got %b want 1", ok); end
        checks++; if (o_Bin !== 13'd17) begin errors++; $display("FAIL refresh_bin1: got %0d want 17", o_Bin); end
        tick();
        tv[0] = 13'd8191;
        tick();
        tick();
        checks++; if (o_BCD4x4 !== 16'h0017 || o_Valid !== 1'b1) begin errors++; $display("FAIL refresh_result1: bcd %h valid %b want 0017 1", o_BCD4x4, o_Valid); end
        checks++; if (o_Bin !== 13'd17) begin errors++; $display("FAIL refresh_bin_stable: got %0d want 17", o_Bin); end
        wait_start(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL refresh_start2: got %b want 1", ok); end
        checks++; if (o_Bin !== 13'd8191) begin errors++; $display("FAIL refresh_bin2: got %0d want 8191", o_Bin); end
        tick();
        tick();
        tick();
        checks++; if (o_BCD4x4 !== 16'h8191) begin errors++; $display("FAIL refresh_result2: got %h want 8191", o_BCD4x4); end
        i_Req = 4'b0000;
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        conv_en = 1'b1;
        tv[0] = 13'd5;
        tv[1] = 13'd6;
        i_Req = 4'b0001;
        wait_start(ok);
        tick();
        tick();
        tick();
        checks++; if (ok !== 1'b1 || o_BCD4x4 !== 16'h0005) begin errors++; $display("FAIL tmo_prior_result: started %b bcd %h want 1 0005", ok, o_BCD4x4); end
        conv_en = 1'b0;
        i_Req   = 4'b0010;
        wait_start(ok);
        checks++; if (ok !== 1'b1 || o_Source !== 3'd1) begin errors++; $display("FAIL tmo_faulty_grant: started %b src %0d want 1 1", ok, o_Source); end
        for (int j = 1; j <= 4; j++) begin
            tick();
            checks++; if (o_Timeout !== 1'b0) begin errors++; $display("FAIL tmo_early_%0d: got %b want 0", j, o_Timeout); end
        end
        tick();
        checks++; if (o_Timeout !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b want 1", o_Timeout); end
        checks++; if (o_BCD4x4 !== 16'h0005 || o_Valid !== 1'b1) begin errors++; $display("FAIL tmo_keep_display: bcd %h valid %b want 0005 1", o_BCD4x4, o_Valid); end
        checks++; if (o_Grant !== 4'b0000) begin errors++; $display("FAIL tmo_grant_drop: got %b want 0000", o_Grant); end
        i_Req = 4'b0011;
        tick();
        checks++; if (o_Timeout !== 1'b0) begin errors++; $display("FAIL tmo_pulse_width: got %b want 0", o_Timeout); end
        checks++; if (o_Bin_Start !== 1'b1 || o_Source !== 3'd0) begin errors++; $display("FAIL tmo_next_source: start %b src %0d want 1 0", o_Bin_Start, o_Source); end
        i_Req = 4'b0000;
    endtask

    task automatic test_drop();
        bit ok;
        do_reset();
        conv_en = 1'b1;
        tv[0] = 13'd42;
        i_Req = 4'b0001;
        wait_start(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL drop_start: got %b want 1", ok); end
        tick();
        i_Req = 4'b0000;
        tick();
        tick();
        checks++; if (o_BCD4x4 !== 16'h0042 || o_Valid !== 1'b1) begin errors++; $display("FAIL drop_result: bcd %h valid %b want 0042 1", o_BCD4x4, o_Valid); end
        for (int j = 0; j < 8; j++) begin
            checks++; if (o_Grant !== 4'b0001) begin errors++; $display("FAIL drop_hold_%0d: grant %b want 0001", j, o_Grant); end
            tick();
        end
        checks++; if (o_Grant !== 4'b0000) begin errors++; $display("FAIL drop_release: got %b want 0000", o_Grant); end
        tick();
        tick();
        tick();
        checks++; if (o_Bin_Start !== 1'b0 || o_Grant !== 4'b0000) begin errors++; $display("FAIL drop_idle: start %b grant %b want 0 0000", o_Bin_Start, o_Grant); end
        checks++; if (o_Valid !== 1'b1 || o_BCD4x4 !== 16'h0042) begin errors++; $display("FAIL drop_display_kept: valid %b bcd %h want 1 0042", o_Valid, o_BCD4x4); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        conv_en = 1'b0;
        tv[0] = 13'd99;
        i_Req = 4'b0001;
        wait_start(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rmid_start: got %b want 1", ok); end
        tick();
        i_RESET = 1'b1;
        i_Req   = 4'b0000;
        tick();
        checks++; if (o_Grant !== 4'b0000 || o_Source !== 3'd0 || o_Bin !== 13'd0) begin errors++; $display("FAIL rmid_outputs: grant %b src %0d bin %0d want 0000 0 0", o_Grant, o_Source, o_Bin); end
        i_RESET = 1'b0;
        man_bcd = 16'h0099;
        man_dv  = 1'b1;
        tick();
        man_dv = 1'b0;
        checks++; if (o_BCD4x4 !== 16'h0000 || o_Valid !== 1'b0) begin errors++; $display("FAIL rmid_late_dv: bcd %h valid %b want 0000 0", o_BCD4x4, o_Valid); end
        tick();
        tick();
        checks++; if (o_Bin_Start !== 1'b0 || o_Grant !== 4'b0000 || o_Timeout !== 1'b0) begin errors++; $display("FAIL rmid_idle: start %b grant %b tmo %b want 0 0000 0", o_Bin_Start, o_Grant, o_Timeout); end
        conv_en = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) tv[k] = 13'd0;
        test_reset();
        test_single();
        test_round_robin();
        test_refresh();
        test_timeout();
        test_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
